// File: rtl/gf163_digit_feeder.sv
// gf163_digit_feeder
// Transmit side of the digit-serial GF(2^163) systolic multiplier. Captures one
// operand set (a, b, g) per in_valid/in_ready handshake, holds a and g steady on
// a_out/g_out, and streams b to the PE row chain as NDIG digits of D bits each
// under a valid/ready handshake. After the last digit is accepted it waits LAT
// flush cycles and pulses op_done for one cycle on the last of them.
//
// Build option:
//   LSB_FIRST_EN  defined   -> digits are sent least-significant first
//                 undefined -> digits are sent most-significant first (default)
// Digit order is the only difference; handshake and timing are identical.
module gf163_digit_feeder #(
    parameter int M    = 163,
    parameter int D    = 16,
    parameter int NDIG = (M + D - 1) / D,
    parameter int LAT  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a_in,
    input  logic [M-1:0] b_in,
    input  logic [M-1:0] g_in,
    output logic [M-1:0] a_out,
    output logic [M-1:0] g_out,
    output logic [D-1:0] dig_out,
    output logic         dig_valid,
    output logic         dig_first,
    output logic         dig_last,
    input  logic         dig_ready,
    output logic         op_done
);

    // b is zero-extended at the top to a whole number of digits.
    localparam int PW = NDIG * D;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [CW-1:0] cnt_q;        // index of the digit currently on dig_out
    logic [FW-1:0] flush_q;      // cycles spent in FLUSH
    logic          busy_q;       // high from capture until the cycle after op_done
    logic [M-1:0]  a_q;
    logic [M-1:0]  g_q;
    logic [PW-1:0] rest_q;       // digits of b not yet placed on dig_out
    logic [D-1:0]  dig_q;
    logic          dig_valid_q;
    logic          dig_first_q;
    logic          dig_last_q;
    logic          op_done_q;

    // ------------------------------------------------------------------
    // Next-value datapath
    // ------------------------------------------------------------------
    logic [PW-1:0] pad_b;
    logic [D-1:0]  load_dig_d;   // first digit of a freshly captured b
    logic [PW-1:0] load_rest_d;  // remaining digits of a freshly captured b
    logic [D-1:0]  next_dig_d;   // digit following the one on dig_out
    logic [PW-1:0] next_rest_d;
    logic [CW-1:0] cnt_d;
    logic [FW-1:0] flush_d;

    assign pad_b = {{(PW - M){1'b0}}, b_in};

    // Digit selection: b is held in a shift register so every digit comes from a
    // fixed slice; the shift direction sets the digit order.
    always_comb begin
        // NOTE: every output of this block is assigned on every pass, so no
        // storage (latch) can be inferred for any of them.
`ifdef LSB_FIRST_EN
        load_dig_d  = pad_b[D-1:0];
        load_rest_d = pad_b >> D;
        next_dig_d  = rest_q[D-1:0];
        next_rest_d = rest_q >> D;
`else
        load_dig_d  = pad_b[PW-1 -: D];
        load_rest_d = pad_b << D;
        next_dig_d  = rest_q[PW-1 -: D];
        next_rest_d = rest_q << D;
`endif
        cnt_d   = cnt_q + 1'b1;
        flush_d = flush_q + 1'b1;
    end

    // Sequencer: IDLE -> STREAM -> FLUSH -> IDLE, with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and digit registers are reset as well, because
            // a_out/g_out/dig_out must read zero after reset or an aborted op.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            flush_q     <= '0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            g_q         <= '0;
            rest_q      <= '0;
            dig_q       <= '0;
            dig_valid_q <= 1'b0;
            dig_first_q <= 1'b0;
            dig_last_q  <= 1'b0;
            op_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the values from before this edge regardless of order.
            op_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q     <= S_STREAM;
                        busy_q      <= 1'b1;
                        a_q         <= a_in;
                        g_q         <= g_in;
                        dig_q       <= load_dig_d;
                        rest_q      <= load_rest_d;
                        cnt_q       <= '0;
                        dig_valid_q <= 1'b1;
                        dig_first_q <= 1'b1;
                        dig_last_q  <= (NDIG == 1);
                    end
                end

                S_STREAM: begin
                    // Without dig_ready everything holds, so the array sees a
                    // stable digit and flags until it accepts them.
                    if (dig_ready) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= S_FLUSH;
                            flush_q     <= '0;
                            dig_q       <= '0;
                            rest_q      <= '0;
                            dig_valid_q <= 1'b0;
                            dig_first_q <= 1'b0;
                            dig_last_q  <= 1'b0;
                            // With a one-cycle flush the first FLUSH cycle is
                            // already the done cycle.
                            op_done_q   <= (LAT == 1);
                        end else begin
                            cnt_q       <= cnt_d;
                            dig_q       <= next_dig_d;
                            rest_q      <= next_rest_d;
                            dig_first_q <= 1'b0;
                            dig_last_q  <= (cnt_d == CNT_LAST);
                        end
                    end
                end

                S_FLUSH: begin
                    if (flush_q == FL_LAST) begin
                        // op_done is high during this cycle; ready for new
                        // operands from the next one.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        flush_q <= '0;
                    end else begin
                        flush_q   <= flush_d;
                        op_done_q <= (flush_d == FL_LAST);
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cnt_q       <= '0;
                    flush_q     <= '0;
                    dig_valid_q <= 1'b0;
                    dig_first_q <= 1'b0;
                    dig_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = ~busy_q;
    assign a_out     = a_q;
    assign g_out     = g_q;
    assign dig_out   = dig_q;
    assign dig_valid = dig_valid_q;
    assign dig_first = dig_first_q;
    assign dig_last  = dig_last_q;
    assign op_done   = op_done_q;

endmodule
